// File: rtl/spike_mac_pkg.sv
// spike_mac_pkg: shared types, default widths and width helpers for the
// spike MAC scheduler and its multiply-accumulate unit.
package spike_mac_pkg;

  localparam int unsigned DEF_NUM_NEURONS = 4;
  localparam int unsigned DEF_NUM_INPUTS  = 8;
  localparam int unsigned DEF_W_WIDTH     = 5;
  localparam int unsigned DEF_X_WIDTH     = 8;
  localparam int unsigned DEF_ACC_WIDTH   = 21;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Full signed product width of a weight times an input.
  function automatic int unsigned prod_width(input int unsigned w, input int unsigned x);
    return w + x;
  endfunction

  // Address/counter width for n entries, never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_mac_unit.sv
// spike_mac_unit: signed multiply-accumulate register.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear accumulator (wins over en_i)
//   en_i       : accumulate w_i*x_i this cycle
//   w_i, x_i   : signed operands
//   acc_o      : registered signed accumulator
//   clip_o_c   : (SPIKE_MAC_SAT_EN only) this cycle's accumulate saturated
// Macro SPIKE_MAC_SAT_EN selects saturating instead of wrapping addition.
module spike_mac_unit
  import spike_mac_pkg::*;
#(
  parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
  parameter int unsigned X_WIDTH   = DEF_X_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [W_WIDTH-1:0]   w_i,
  input  logic signed [X_WIDTH-1:0]   x_i,
`ifdef SPIKE_MAC_SAT_EN
  output logic                        clip_o_c,
`endif
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  localparam int unsigned P_WIDTH = prod_width(W_WIDTH, X_WIDTH);
  // One guard bit above the wider operand so the sum never wraps internally.
  localparam int unsigned S_WIDTH = ((ACC_WIDTH > P_WIDTH) ? ACC_WIDTH : P_WIDTH) + 1;

  logic signed [P_WIDTH-1:0]   prod_c;
  logic signed [S_WIDTH-1:0]   sum_c;
  logic signed [ACC_WIDTH-1:0] acc_next_c;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

`ifdef SPIKE_MAC_SAT_EN
  localparam logic signed [S_WIDTH-1:0] SUM_MAX = S_WIDTH'({1'b0, {(ACC_WIDTH-1){1'b1}}});
  localparam logic signed [S_WIDTH-1:0] SUM_MIN = ~SUM_MAX;
  logic clip_c;
`endif

  // Product, extended sum and the next accumulator value.
  always_comb begin
    prod_c = P_WIDTH'(w_i) * P_WIDTH'(x_i);
    sum_c  = S_WIDTH'(acc_q) + S_WIDTH'(prod_c);
`ifdef SPIKE_MAC_SAT_EN
    clip_c = 1'b0;
    if (sum_c > SUM_MAX) begin
      acc_next_c = SUM_MAX[ACC_WIDTH-1:0];
      clip_c     = 1'b1;
    end else if (sum_c < SUM_MIN) begin
      acc_next_c = SUM_MIN[ACC_WIDTH-1:0];
      clip_c     = 1'b1;
    end else begin
      acc_next_c = ACC_WIDTH'(sum_c);
    end
`else
    acc_next_c = ACC_WIDTH'(sum_c);
`endif
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_next_c;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
`ifdef SPIKE_MAC_SAT_EN
  assign clip_o_c = en_i & ~clr_i & clip_c;
`endif

endmodule

// File: rtl/spike_mac_scheduler.sv
// spike_mac_scheduler: sequences one MAC unit over NUM_NEURONS neurons of
// NUM_INPUTS synapses each, thresholds every sum and publishes a spike vector.
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : pass request, honoured only in IDLE
//   threshold_i : signed firing threshold, latched at start acceptance
//   busy_o      : pass in progress (cycle after acceptance through DONE)
//   done_o      : one-cycle pulse at pass end
//   w_addr_o    : weight address neuron*NUM_INPUTS+idx
//   x_addr_o    : input address idx
//   rd_en_o     : read strobe for both memories; data returns next cycle
//   w_i, x_i    : signed weight / input read data
//   spikes_o    : spike vector of the last completed pass
//   acc_o       : sum of the most recently compared neuron
//   sat_o       : (SPIKE_MAC_SAT_EN only) sticky clip flag for the pass
// Macro SPIKE_MAC_SAT_EN enables saturating accumulation and sat_o.
module spike_mac_scheduler
  import spike_mac_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int unsigned NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int unsigned W_WIDTH     = DEF_W_WIDTH,
  parameter int unsigned X_WIDTH     = DEF_X_WIDTH,
  parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start_i,
  input  logic signed [ACC_WIDTH-1:0]                     threshold_i,
  output logic                                            busy_o,
  output logic                                            done_o,
  output logic [addr_width(NUM_NEURONS*NUM_INPUTS)-1:0]   w_addr_o,
  output logic [addr_width(NUM_INPUTS)-1:0]               x_addr_o,
  output logic                                            rd_en_o,
  input  logic signed [W_WIDTH-1:0]                       w_i,
  input  logic signed [X_WIDTH-1:0]                       x_i,
`ifdef SPIKE_MAC_SAT_EN
  output logic                                            sat_o,
`endif
  output logic [NUM_NEURONS-1:0]                          spikes_o,
  output logic signed [ACC_WIDTH-1:0]                     acc_o
);

  localparam int unsigned WA_WIDTH = addr_width(NUM_NEURONS * NUM_INPUTS);
  localparam int unsigned XA_WIDTH = addr_width(NUM_INPUTS);
  localparam int unsigned NR_WIDTH = addr_width(NUM_NEURONS);
  localparam logic [XA_WIDTH-1:0] LAST_IDX    = XA_WIDTH'(NUM_INPUTS - 1);
  localparam logic [NR_WIDTH-1:0] LAST_NEURON = NR_WIDTH'(NUM_NEURONS - 1);

  state_t                      state_q, state_d;
  logic [NR_WIDTH-1:0]         neuron_q, neuron_d;
  logic [XA_WIDTH-1:0]         idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] thr_q, thr_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        rd_en_q, rd_en_d;
  logic                        valid_q;
  logic [WA_WIDTH-1:0]         w_addr_q, w_addr_d;
  logic [XA_WIDTH-1:0]         x_addr_q, x_addr_d;
  logic [NUM_NEURONS-1:0]      shadow_q, shadow_d;
  logic [NUM_NEURONS-1:0]      spikes_q, spikes_d;
  logic signed [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic signed [ACC_WIDTH-1:0] acc_c;
  logic                        acc_clr_c;
`ifdef SPIKE_MAC_SAT_EN
  logic                        sat_q, sat_d;
  logic                        clip_c;
`endif

  function automatic logic [WA_WIDTH-1:0] w_addr_of(input logic [NR_WIDTH-1:0] n,
                                                    input logic [XA_WIDTH-1:0] i);
    return WA_WIDTH'(n) * WA_WIDTH'(NUM_INPUTS) + WA_WIDTH'(i);
  endfunction

  // The accumulator input is qualified by the registered read strobe, so
  // each product lands exactly one cycle after its address was issued.
  spike_mac_unit #(
    .W_WIDTH   (W_WIDTH),
    .X_WIDTH   (X_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (acc_clr_c),
    .en_i     (valid_q),
    .w_i      (w_i),
    .x_i      (x_i),
`ifdef SPIKE_MAC_SAT_EN
    .clip_o_c (clip_c),
`endif
    .acc_o    (acc_c)
  );

  // Next-state and next-output logic; outputs are decoded from the next state.
  always_comb begin
    state_d   = state_q;
    neuron_d  = neuron_q;
    idx_d     = idx_q;
    thr_d     = thr_q;
    rd_en_d   = 1'b0;
    w_addr_d  = w_addr_q;
    x_addr_d  = x_addr_q;
    shadow_d  = shadow_q;
    spikes_d  = spikes_q;
    acc_out_d = acc_out_q;
    acc_clr_c = 1'b0;
`ifdef SPIKE_MAC_SAT_EN
    sat_d     = sat_q | clip_c;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          thr_d     = threshold_i;
          neuron_d  = '0;
          idx_d     = '0;
          acc_clr_c = 1'b1;
          rd_en_d   = 1'b1;
          w_addr_d  = '0;
          x_addr_d  = '0;
          state_d   = RUN;
`ifdef SPIKE_MAC_SAT_EN
          sat_d     = 1'b0;
`endif
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d    = idx_q + XA_WIDTH'(1);
          rd_en_d  = 1'b1;
          w_addr_d = w_addr_of(neuron_q, idx_d);
          x_addr_d = idx_d;
        end
      end
      DRAIN: begin
        state_d = CMP;
      end
      CMP: begin
        shadow_d[neuron_q] = (acc_c >= thr_q);
        acc_out_d          = acc_c;
        if (neuron_q != LAST_NEURON) begin
          neuron_d  = neuron_q + NR_WIDTH'(1);
          idx_d     = '0;
          acc_clr_c = 1'b1;
          rd_en_d   = 1'b1;
          w_addr_d  = w_addr_of(neuron_d, '0);
          x_addr_d  = '0;
          state_d   = RUN;
        end else begin
          // Publish the whole pass at once, alongside the done pulse.
          spikes_d = shadow_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      neuron_q  <= '0;
      idx_q     <= '0;
      thr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      valid_q   <= 1'b0;
      w_addr_q  <= '0;
      x_addr_q  <= '0;
      shadow_q  <= '0;
      spikes_q  <= '0;
      acc_out_q <= '0;
`ifdef SPIKE_MAC_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      neuron_q  <= neuron_d;
      idx_q     <= idx_d;
      thr_q     <= thr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      valid_q   <= rd_en_q;
      w_addr_q  <= w_addr_d;
      x_addr_q  <= x_addr_d;
      shadow_q  <= shadow_d;
      spikes_q  <= spikes_d;
      acc_out_q <= acc_out_d;
`ifdef SPIKE_MAC_SAT_EN
      sat_q     <= sat_d;
`endif
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign rd_en_o  = rd_en_q;
  assign w_addr_o = w_addr_q;
  assign x_addr_o = x_addr_q;
  assign spikes_o = spikes_q;
  assign acc_o    = acc_out_q;
`ifdef SPIKE_MAC_SAT_EN
  assign sat_o    = sat_q;
`endif

endmodule

// File: tb/tb_spike_mac_scheduler.sv
// Testbench for spike_mac_scheduler: vector table, hand-written corner
// sequences and random passes checked against a behavioural sum model.
// A second instance with ACC_WIDTH=12 exercises overflow (wrap or, with
// SPIKE_MAC_SAT_EN, saturation).
module tb_spike_mac_scheduler;

  localparam int NN  = 4;
  localparam int NI  = 8;
  localparam int AW  = 21;
  localparam int AW2 = 12;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic signed [AW-1:0]  thr;
  logic signed [AW2-1:0] thr12;

  logic              busy, done, rd_en;
  logic [4:0]        w_addr;
  logic [2:0]        x_addr;
  logic signed [4:0] w_in;
  logic signed [7:0] x_in;
  logic [NN-1:0]     spikes;
  logic signed [AW-1:0] acc;

  logic              busy12, done12, rd_en12;
  logic [4:0]        w_addr12;
  logic [2:0]        x_addr12;
  logic signed [4:0] w_in12;
  logic signed [7:0] x_in12;
  logic [NN-1:0]     spikes12;
  logic signed [AW2-1:0] acc12;
`ifdef SPIKE_MAC_SAT_EN
  logic sat, sat12;
`endif

  logic signed [4:0] w_mem [NN*NI];
  logic signed [7:0] x_mem [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spike_mac_scheduler dut (
    .clk(clk), .rst(rst), .start_i(start), .threshold_i(thr),
    .busy_o(busy), .done_o(done), .w_addr_o(w_addr), .x_addr_o(x_addr),
    .rd_en_o(rd_en), .w_i(w_in), .x_i(x_in),
`ifdef SPIKE_MAC_SAT_EN
    .sat_o(sat),
`endif
    .spikes_o(spikes), .acc_o(acc)
  );

  spike_mac_scheduler #(.ACC_WIDTH(AW2)) dut12 (
    .clk(clk), .rst(rst), .start_i(start), .threshold_i(thr12),
    .busy_o(busy12), .done_o(done12), .w_addr_o(w_addr12), .x_addr_o(x_addr12),
    .rd_en_o(rd_en12), .w_i(w_in12), .x_i(x_in12),
`ifdef SPIKE_MAC_SAT_EN
    .sat_o(sat12),
`endif
    .spikes_o(spikes12), .acc_o(acc12)
  );

  // Synchronous read memories; junk on the bus when not reading.
  always @(posedge clk) begin
    if (rd_en) begin
      w_in <= w_mem[w_addr];
      x_in <= x_mem[x_addr];
    end else begin
      w_in <= 5'($urandom);
      x_in <= 8'($urandom);
    end
    if (rd_en12) begin
      w_in12 <= w_mem[w_addr12];
      x_in12 <= x_mem[x_addr12];
    end else begin
      w_in12 <= 5'($urandom);
      x_in12 <= 8'($urandom);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int k = 0; k < NN*NI; k++) w_mem[k] = '0;
    for (int k = 0; k < NI; k++) x_mem[k] = '0;
    case (pat)
      0: begin
        x_mem[0] = 8'(-15);
        for (int n = 0; n < NN; n++) w_mem[n*NI] = 5'(11);
      end
      1: begin
        x_mem[0] = 8'(10);
        for (int n = 0; n < NN; n++) w_mem[n*NI] = 5'(10);
      end
      2: begin
        for (int k = 0; k < NI; k++) x_mem[k] = 8'(-128);
        for (int k = 0; k < NN*NI; k++) w_mem[k] = 5'(-16);
      end
      3: begin
        for (int k = 0; k < NI; k++) x_mem[k] = 8'(-128);
        for (int k = 0; k < NN*NI; k++) w_mem[k] = 5'(15);
      end
      4: begin
        x_mem[0] = 8'(50);
        for (int n = 0; n < NN; n++) w_mem[n*NI] = 5'(n + 1);
      end
      default: begin
        for (int k = 0; k < NI; k++) x_mem[k] = 8'($urandom);
        for (int k = 0; k < NN*NI; k++) w_mem[k] = 5'($urandom);
      end
    endcase
  endtask

  // Reference: plain dot products, wrapped to the accumulator width.
  task automatic model(input int thr_v, output logic [NN-1:0] spk, output int last);
    spk  = '0;
    last = 0;
    for (int n = 0; n < NN; n++) begin
      int s;
      logic signed [AW-1:0] t;
      s = 0;
      for (int i = 0; i < NI; i++) s += int'(w_mem[n*NI+i]) * int'(x_mem[i]);
      t = s[AW-1:0];
      spk[n] = (int'(t) >= thr_v);
      last = int'(t);
    end
  endtask

  // Starts a pass (cycle 0 = IDLE with start), optionally changes the
  // threshold mid-pass, returns the cycle in which done_o was seen.
  task automatic run_pass(input int thr_v, input int chg_cyc, input int thr_new,
                          output int done_cyc);
    int c;
    @(negedge clk);
    start = 1'b1;
    thr   = AW'(thr_v);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    chk("busy_cycle1", longint'(busy), 1);
    while (!done && c < 100) begin
      if (c == chg_cyc) thr = AW'(thr_new);
      @(negedge clk);
      c++;
    end
    done_cyc = c;
    chk("done12_aligned", longint'(done12), longint'(done));
    chk("busy_in_done", longint'(busy), 1);
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 0);
    chk("busy_after_done", longint'(busy), 0);
  endtask

  typedef struct {
    string         name;
    int            pat;
    int            thr;
    int            exp_acc;
    logic [NN-1:0] exp_spk;
  } vec_t;

  vec_t vec [8];

  initial begin
    int dc;
    int n_done, first_dc, second_dc, seen;
    logic [NN-1:0] m_spk;
    int m_last, r_thr;

    vec[0] = '{"single_weight", 0, -200,   -165,   4'b1111};
    vec[1] = '{"thr_equal",     1,  100,    100,   4'b1111};
    vec[2] = '{"thr_above",     1,  101,    100,   4'b0000};
    vec[3] = '{"max_pos",       2,    0,  16384,   4'b1111};
    vec[4] = '{"max_pos_eq",    2, 16384, 16384,   4'b1111};
    vec[5] = '{"max_pos_above", 2, 16385, 16384,   4'b0000};
    vec[6] = '{"max_neg",       3,    0, -15360,   4'b0000};
    vec[7] = '{"ramp",          4,  120,    200,   4'b1100};

    rst   = 1'b1;
    start = 1'b0;
    thr   = '0;
    thr12 = '0;
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_busy",   longint'(busy), 0);
    chk("rst_done",   longint'(done), 0);
    chk("rst_rd_en",  longint'(rd_en), 0);
    chk("rst_spikes", longint'(spikes), 0);
    chk("rst_acc",    longint'(acc), 0);
    chk("rst_w_addr", longint'(w_addr), 0);
    chk("rst_x_addr", longint'(x_addr), 0);
    chk("rst_busy12", longint'(busy12), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      fill(vec[i].pat);
      run_pass(vec[i].thr, -1, 0, dc);
      chk($sformatf("%s/done_cycle", vec[i].name), dc, 41);
      chk($sformatf("%s/acc", vec[i].name), longint'(acc), vec[i].exp_acc);
      chk($sformatf("%s/spikes", vec[i].name), longint'(spikes), longint'(vec[i].exp_spk));
`ifdef SPIKE_MAC_SAT_EN
      chk($sformatf("%s/sat", vec[i].name), longint'(sat), 0);
`endif
      if (vec[i].pat == 2) begin
`ifdef SPIKE_MAC_SAT_EN
        chk("acc12_saturated", longint'(acc12), 2047);
        chk("sat12_set", longint'(sat12), 1);
`else
        chk("acc12_wrapped", longint'(acc12), 0);
`endif
        chk("spikes12", longint'(spikes12), 4'b1111);
      end
    end

    // Threshold change mid-pass must not affect the result.
    fill(4);
    run_pass(120, 15, -1000, dc);
    chk("thr_change/done_cycle", dc, 41);
    chk("thr_change/spikes", longint'(spikes), 4'b1100);
    chk("thr_change/acc", longint'(acc), 200);

    // Reset in cycle 20 of a pass.
    fill(0);
    @(negedge clk);
    start = 1'b1;
    thr   = AW'(-200);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy",   longint'(busy), 0);
    chk("midrst_spikes", longint'(spikes), 0);
    chk("midrst_acc",    longint'(acc), 0);
    chk("midrst_rd_en",  longint'(rd_en), 0);
    chk("midrst_done",   longint'(done), 0);
    rst  = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrst_no_done", seen, 0);
    run_pass(-200, -1, 0, dc);
    chk("after_rst/done_cycle", dc, 41);
    chk("after_rst/acc", longint'(acc), -165);
    chk("after_rst/spikes", longint'(spikes), 4'b1111);

    // start_i held high: one pass per 42 cycles, no queued requests.
    fill(1);
    @(negedge clk);
    start    = 1'b1;
    thr      = AW'(100);
    n_done   = 0;
    first_dc = 0;
    second_dc = 0;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) first_dc = c;
        else if (n_done == 2) second_dc = c;
      end
    end
    start = 1'b0;
    chk("held/done_count", n_done, 2);
    chk("held/first_done", first_dc, 41);
    chk("held/second_done", second_dc, 83);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("held/third_done", seen, 1);
    @(negedge clk);
    chk("held/spikes", longint'(spikes), 4'b1111);

    // Random passes against the model.
    for (int r = 0; r < 8; r++) begin
      fill(99);
      r_thr = int'($urandom_range(0, 6000)) - 3000;
      model(r_thr, m_spk, m_last);
      run_pass(r_thr, -1, 0, dc);
      chk($sformatf("rand%0d/done_cycle", r), dc, 41);
      chk($sformatf("rand%0d/acc", r), longint'(acc), m_last);
      chk($sformatf("rand%0d/spikes", r), longint'(spikes), longint'(m_spk));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_mac_scheduler.md
Name: spike_mac_scheduler

Overview:
- Time-multiplexes one signed multiply-accumulate unit across NUM_NEURONS neurons. Each neuron has NUM_INPUTS synapses.
- Per neuron: fetches weight/input pairs from external synchronous memories and accumulates w*x.
- Compares the sum against a threshold and records one spike bit per neuron.
- Sits between the annealing/control logic and the weight/activation memories of the SNN core.

Parameters:
- NUM_NEURONS, 4, number of neurons sequenced per pass
- NUM_INPUTS, 8, synapses per neuron
- W_WIDTH, 5, signed weight width
- X_WIDTH, 8, signed input width
- ACC_WIDTH, 21, signed accumulator width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  pass request; sampled only in IDLE
- threshold_i  in  ACC_WIDTH  signed firing threshold; latched when start is accepted
- busy_o  out  1  high from the cycle after start acceptance through DONE
- done_o  out  1  one-cycle pulse at pass end
- w_addr_o  out  clog2(NUM_NEURONS*NUM_INPUTS)  weight address = neuron*NUM_INPUTS+idx
- x_addr_o  out  clog2(NUM_INPUTS)  input address = idx
- rd_en_o  out  1  read strobe for both memories
- w_i  in  W_WIDTH  signed weight; valid the cycle after rd_en_o
- x_i  in  X_WIDTH  signed input; valid the cycle after rd_en_o
- spikes_o  out  NUM_NEURONS  spike vector of the last completed pass
- acc_o  out  ACC_WIDTH  signed sum of the most recently compared neuron

Behaviour:
- Reset values: state IDLE; busy_o, done_o, rd_en_o, spikes_o, acc_o all 0; addresses 0; counters 0.
- States: IDLE, RUN, DRAIN, CMP, DONE.
- Cycle numbering: cycle 0 is the IDLE cycle with start_i=1. The block latches threshold_i, clears neuron/idx/accumulator and moves to RUN.
- RUN:
  - Per cycle: rd_en_o=1, addresses for the current idx, idx++.
  - When idx=NUM_INPUTS-1 is issued, go to DRAIN.
- Read pipeline:
  - A one-cycle valid register follows rd_en_o.
  - Whenever it is set, acc <= acc + sext(w_i*x_i).
  - The product is a full W_WIDTH+X_WIDTH signed multiply, sign-extended to ACC_WIDTH.
- DRAIN: rd_en_o=0; the last product is accumulated; go to CMP.
- CMP:
  - shadow[neuron] <= (acc >= threshold), signed compare; acc_o <= acc.
  - If neuron < NUM_NEURONS-1: neuron++, idx=0, acc cleared, go to RUN.
  - Otherwise go to DONE.
- DONE: spikes_o <= shadow (atomic update); done_o=1 for exactly this cycle; busy_o still 1; next state IDLE.
- Latency:
  - NUM_INPUTS+2 cycles per neuron.
  - done_o is high in cycle NUM_NEURONS*(NUM_INPUTS+2)+1 (41 with defaults).
  - Back-to-back: start_i may be sampled in the IDLE cycle after DONE.
- Boundary rules:
  - start_i while not IDLE: ignored, not queued.
  - threshold_i changes mid-pass: no effect.
  - spikes_o and acc_o hold between passes. spikes_o never shows a partial pass.
  - Overflow with feature off: two's-complement wrap at ACC_WIDTH. Defaults cannot overflow (max |sum| = 8*2048 = 16384).
  - rst mid-pass: IDLE next cycle, all outputs to reset values, no done_o, in-flight read discarded.
  - NUM_INPUTS=1: RUN lasts one cycle.

Optional Feature:
- Macro: SPIKE_MAC_SAT_EN.
- Defined: each accumulate saturates at +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1). A sticky sat_o output (1 bit) is added; it is cleared at start acceptance and set if any neuron clipped in the pass.
- Undefined: wrap-around arithmetic; no sat_o port.

Decomposition:
- Package spike_mac_pkg:
  - state_t enum (IDLE, RUN, DRAIN, CMP, DONE)
  - default width localparams
  - product-width function (W_WIDTH+X_WIDTH)
- Sub-module spike_mac_unit: signed multiply + accumulate with clear/enable inputs and optional saturation. The scheduler instantiates one.

Test Plan:
- Single weight: w=11, x=-15 at idx0, all other pairs 0, threshold=-200 -> acc_o=-165; spike bit 1 for every neuron; done_o pulse in cycle 41.
- Threshold equality: per-neuron sum exactly 100, threshold 100 -> spike 1; threshold 101 -> spike 0.
- Extremes: all w=-16, x=-128 -> acc_o=16384, no wrap; all w=15, x=-128 -> acc_o=-15360.
- start_i held high throughout -> exactly one done_o per 42 cycles (41 + IDLE). Mid-pass threshold change -> result unchanged.
- rst asserted in cycle 20 -> busy_o=0 and spikes_o=0 next cycle; no done_o. A new start afterwards completes normally.
- With SPIKE_MAC_SAT_EN and ACC_WIDTH=12: all w=-16, x=-128 -> acc_o=2047 and sat_o=1. Without the macro, the same stimulus wraps -> acc_o=0.
